// File: rtl/avalon_mem_slave.sv
// Avalon-MM word RAM responder: decodes a low data window and the MIPS reset-vector
// window into one array, stalls each access for a fixed count and applies byte lanes.
module avalon_mem_slave #(
  parameter int          MEM_AW       = 10,
  parameter int          WAIT_CYCLES  = 1,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter string       INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic              err,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_word,
  input  logic [31:0]       bd_wdata,
  output logic [31:0]       bd_rdata
);

  localparam int          DEPTH        = 1 << MEM_AW;
  localparam logic [31:0] REGION_BYTES = 32'(4 * (DEPTH / 2));

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] word_q;
  logic              mapped_q;
  logic              write_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  logic              req;
  logic [31:0]       ivec_off;
  logic              dec_mapped;
  logic [MEM_AW-1:0] dec_word;

  assign req = read | write;

  // Data window fills the lower half of the array, instruction window the upper half.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    ivec_off   = address - RESET_VECTOR;
    dec_mapped = 1'b0;
    dec_word   = '0;
    if (address < REGION_BYTES) begin
      dec_mapped = 1'b1;
      dec_word   = {1'b0, address[MEM_AW:2]};
    end else if (address >= RESET_VECTOR && ivec_off < REGION_BYTES) begin
      dec_mapped = 1'b1;
      dec_word   = {1'b1, ivec_off[MEM_AW:2]};
    end
  end

  // Stall must rise in the same cycle the request appears, so IDLE drives it combinationally.
  assign waitrequest = !reset && ((state == IDLE && req) || state == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      readdata <= '0;
      err      <= 1'b0;
      word_q   <= '0;
      mapped_q <= 1'b0;
      write_q  <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= BUSY;
            cnt      <= 4'(WAIT_CYCLES - 1);
            word_q   <= dec_word;
            mapped_q <= dec_mapped;
            write_q  <= write && !read;
            be_q     <= byteenable;
            wdata_q  <= writedata;
            if ((read && write) || !dec_mapped) err <= 1'b1;
          end
        end
        BUSY: begin
          if (!req) begin
            // Master abandoned the request: abort without committing anything.
            state <= IDLE;
            err   <= 1'b1;
          end else if (cnt == 4'd0) begin
            state <= DONE;
            if (!write_q) readdata <= mapped_q ? mem[word_q] : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset branch; contents survive reset and map onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && write_q && mapped_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end else if (bd_we && state == IDLE && !req) begin
      mem[bd_word] <= bd_wdata;
    end
  end

  assign bd_rdata = mem[bd_word];

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Directed bench for avalon_mem_slave: one instance with a 1-cycle stall, one with 4,
// driven by a simple bus master task and checked against hand-computed values.
module tb_avalon_mem_slave;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   address;
  logic [3:0]    byteenable;
  logic [31:0]   writedata;
  logic          rd1, wr1, rd4, wr4;
  logic          bd_we;
  logic [AW-1:0] bd_word;
  logic [31:0]   bd_wdata;
  logic [31:0]   rdata1, rdata4, bdr1, bdr4;
  logic          wait1, wait4, err1, err4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  avalon_mem_slave #(.MEM_AW(AW), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .read(rd1), .write(wr1),
    .byteenable(byteenable), .writedata(writedata), .readdata(rdata1),
    .waitrequest(wait1), .err(err1), .bd_we(bd_we), .bd_word(bd_word),
    .bd_wdata(bd_wdata), .bd_rdata(bdr1)
  );

  avalon_mem_slave #(.MEM_AW(AW), .WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .read(rd4), .write(wr4),
    .byteenable(byteenable), .writedata(writedata), .readdata(rdata4),
    .waitrequest(wait4), .err(err4), .bd_we(bd_we), .bd_word(bd_word),
    .bd_wdata(bd_wdata), .bd_rdata(bdr4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int w, input logic [31:0] d);
    bd_word  = AW'(w);
    bd_wdata = d;
    bd_we    = 1'b1;
    tick();
    bd_we    = 1'b0;
  endtask

  task automatic peek(input bit sel, input int w, output logic [31:0] d);
    bd_word = AW'(w);
    #1;
    d = sel ? bdr4 : bdr1;
  endtask

  // One complete bus transaction; returns the number of stalled cycles and the read data.
  task automatic access(input bit sel, input bit r, input bit w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int waits, output logic [31:0] rd);
    address    = a;
    byteenable = be;
    writedata  = wd;
    if (sel) begin rd4 = r; wr4 = w; end
    else     begin rd1 = r; wr1 = w; end
    waits = 0;
    #1;
    while ((sel ? wait4 : wait1) && waits < 40) begin
      waits++;
      tick();
    end
    if (waits >= 40) check("access_timeout", 32'(sel ? wait4 : wait1), 32'd0);
    rd = sel ? rdata4 : rdata1;
    tick();
    rd1 = 1'b0; wr1 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [31:0] d;

    reset = 1'b1; address = '0; byteenable = '0; writedata = '0;
    rd1 = 1'b1; wr1 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
    bd_we = 1'b0; bd_word = '0; bd_wdata = '0;
    tick(); tick(); tick();
    // Reset holds waitrequest low even with a request present.
    check("rst_wait", 32'(wait1), 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    rd1 = 1'b0;
    reset = 1'b0;
    tick();

    // Data-region read
    bd_write(100, 32'd123);
    access(0, 1, 0, 32'd400, 4'hF, '0, w, d);
    check("rd_waits", 32'(w), 32'd2);
    check("rd_data", d, 32'd123);
    check("rd_err", 32'(err1), 32'd0);

    // Reset-vector region
    bd_write(512, 32'h8C010064);
    bd_write(513, 32'h0BADF00D);
    access(0, 1, 0, 32'hBFC00000, 4'hF, '0, w, d);
    check("rv_fetch0", d, 32'h8C010064);
    access(0, 1, 0, 32'hBFC00004, 4'hF, '0, w, d);
    check("rv_fetch1", d, 32'h0BADF00D);

    // Last word of each region
    bd_write(511, 32'h00005110);
    bd_write(1023, 32'h00010230);
    access(0, 1, 0, 32'h000007FC, 4'hF, '0, w, d);
    check("last_data", d, 32'h00005110);
    access(0, 1, 0, 32'hBFC007FC, 4'hF, '0, w, d);
    check("last_instr", d, 32'h00010230);

    // Byte lanes on word 206
    bd_write(206, 32'hAABBCCDD);
    access(0, 0, 1, 32'd824, 4'b0001, 32'd9, w, d);
    peek(0, 206, d);
    check("be_0001", d, 32'hAABBCC09);
    access(0, 0, 1, 32'd824, 4'b0011, 32'h00001234, w, d);
    peek(0, 206, d);
    check("be_0011", d, 32'hAABB1234);
    access(0, 0, 1, 32'd824, 4'b0000, 32'hFFFFFFFF, w, d);
    check("be_0000_waits", 32'(w), 32'd2);
    peek(0, 206, d);
    check("be_0000", d, 32'hAABB1234);
    check("be_err", 32'(err1), 32'd0);

    // Four-cycle stall instance, back-to-back writes
    access(1, 0, 1, 32'd800, 4'hF, 32'hA5A5A5A5, w, d);
    check("w4_waits_a", 32'(w), 32'd5);
    access(1, 0, 1, 32'd804, 4'hF, 32'h5A5A5A5A, w, d);
    check("w4_waits_b", 32'(w), 32'd5);
    peek(1, 200, d);
    check("w4_mem200", d, 32'hA5A5A5A5);
    peek(1, 201, d);
    check("w4_mem201", d, 32'h5A5A5A5A);
    access(1, 1, 0, 32'd800, 4'hF, '0, w, d);
    check("w4_rd_waits", 32'(w), 32'd5);
    check("w4_rd_data", d, 32'hA5A5A5A5);

    // Master drops the request mid-stall
    bd_write(202, 32'h00000022);
    check("drop_err_pre", 32'(err4), 32'd0);
    address = 32'd808; byteenable = 4'hF; writedata = 32'h0000FFFF; wr4 = 1'b1;
    tick(); tick();
    check("drop_busy", 32'(wait4), 32'd1);
    wr4 = 1'b0;
    tick();
    check("drop_err", 32'(err4), 32'd1);
    check("drop_idle", 32'(wait4), 32'd0);
    peek(1, 202, d);
    check("drop_mem", d, 32'h00000022);

    // Read and write together: read wins, memory untouched, error flagged
    access(0, 1, 1, 32'd400, 4'hF, 32'hDEADBEEF, w, d);
    check("rw_data", d, 32'd123);
    peek(0, 100, d);
    check("rw_mem", d, 32'd123);
    check("rw_err", 32'(err1), 32'd1);
    access(0, 1, 0, 32'd400, 4'hF, '0, w, d);
    check("err_sticky", 32'(err1), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    check("err_cleared", 32'(err1), 32'd0);

    // Unmapped addresses
    access(0, 1, 0, 32'h00001000, 4'hF, '0, w, d);
    check("unmap_data", d, 32'd0);
    check("unmap_err", 32'(err1), 32'd1);
    access(0, 1, 0, 32'd400, 4'hF, '0, w, d);
    access(0, 1, 0, 32'h00000800, 4'hF, '0, w, d);
    check("past_data", d, 32'd0);
    access(0, 1, 0, 32'd400, 4'hF, '0, w, d);
    access(0, 1, 0, 32'hBFC00800, 4'hF, '0, w, d);
    check("past_instr", d, 32'd0);
    bd_write(0, 32'h00000077);
    access(0, 0, 1, 32'h00000800, 4'hF, 32'h000000EE, w, d);
    peek(0, 0, d);
    check("unmap_wr0", d, 32'h00000077);
    peek(0, 512, d);
    check("unmap_wr512", d, 32'h8C010064);

    // Reset in the middle of a write to word 201
    bd_write(201, 32'h00000033);
    access(0, 1, 0, 32'd400, 4'hF, '0, w, d);
    check("pre_rst_data", d, 32'd123);
    address = 32'd804; byteenable = 4'hF; writedata = 32'd5; wr1 = 1'b1;
    tick();
    check("mid_busy", 32'(wait1), 32'd1);
    reset = 1'b1; wr1 = 1'b0;
    tick();
    check("mid_wait", 32'(wait1), 32'd0);
    check("mid_rdata", rdata1, 32'd0);
    check("mid_err", 32'(err1), 32'd0);
    reset = 1'b0;
    tick(); tick();
    peek(0, 201, d);
    check("mid_mem", d, 32'h00000033);
    access(0, 1, 0, 32'd400, 4'hF, '0, w, d);
    check("post_rst_waits", 32'(w), 32'd2);
    check("post_rst_data", d, 32'd123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
